rr_grant_arbiter: RTL
=====================

// Module: rr_grant_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource between N_REQ requesters.
//  Grants are held (locked) until the owner drops its request.
//  Grant is presented both encoded (gnt_id) and one-hot (gnt), the one-hot form being the decode of gnt_id.
//  Sits between requesting engines and a shared datapath/bus; gnt_id drives the datapath select mux.
// PARAMETERS
//  N_REQ     4   number of requesters; power of two, >= 2
//  MAX_HOLD  16  max cycles one grant may be held (used only with ARB_HOLD_TIMEOUT_EN); >= 1
// PORTS
//  clk        in   1                 clock, all logic on rising edge
//  rst_n      in   1                 reset, synchronous, active-low
//  req        in   N_REQ             request per requester, level-sensitive
//  gnt        out  N_REQ             one-hot grant, registered; all-zero when none
//  gnt_id     out  $clog2(N_REQ)     index of current owner; valid only when gnt_valid
//  gnt_valid  out  1                 a grant is active (== |gnt)
//  timeout    out  1                 one-cycle pulse on forced release; constant 0 without macro
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE,
//   ptr=0 (requester 0 highest priority), hold_cnt=0, mask=0. Reset mid-grant drops grant at that edge.
//  States: IDLE, GRANT.
//  IDLE: if any (req & ~mask) set, select first set bit scanning ptr, ptr+1, ... mod N_REQ;
//   next edge: gnt=onehot(sel), gnt_id=sel, gnt_valid=1, state=GRANT, hold_cnt=0. Latency req->gnt = 1 cycle.
//   If no eligible request: stay IDLE, outputs 0.
//  GRANT: requests from others are ignored (not queued, not sampled).
//   req[gnt_id]=1: hold grant unchanged.
//   req[gnt_id]=0: next edge gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod N_REQ, state=IDLE.
//  Mandatory 1-cycle bubble (gnt=0) between any two grants, including re-grant to same requester.
//  Ptr wraps N_REQ-1 -> 0. Requests arriving in the same cycle resolved purely by ptr order.
//  gnt is always one-hot or zero; never two bits set; gnt == (gnt_valid << gnt_id).
// CONFIGURATION
//  ARB_HOLD_TIMEOUT_EN defined:
//   hold_cnt counts cycles in GRANT (saturating width $clog2(MAX_HOLD+1)).
//   When hold_cnt reaches MAX_HOLD-1 with req[gnt_id] still 1: next edge gnt=0, gnt_valid=0,
//    timeout=1 for exactly that one cycle, ptr=gnt_id+1 mod N_REQ, mask[gnt_id]=1, state=IDLE.
//   mask[i] clears on the first edge where req[i]=0; masked requester ineligible until then.
//   Owner dropping req on the same cycle as expiry: normal release, timeout stays 0, no mask.
//   Grant held at most MAX_HOLD cycles.
//  ARB_HOLD_TIMEOUT_EN undefined: no counter, no mask; timeout tied 0; grants held indefinitely.
// TESTING (N_REQ=4, MAX_HOLD=4 for timeout tests)
//  1 Reset: rst_n=0 two cycles with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0 throughout.
//  2 Single: req=4'b0100 from cycle t -> gnt=4'b0100, gnt_id=2 at t+1; req=0 at t+5 -> gnt=0 at t+6.
//  3 Rotation: req=4'b1111, each owner drops its req 3 cycles after grant and reasserts next cycle
//    -> grant order 0,1,2,3,0 with one zero cycle between grants.
//  4 Ptr wrap: after grant to 2 released, req=4'b1010 simultaneously -> gnt_id=3 first, then 1.
//  5 Mid-grant reset: gnt=4'b0010 held, rst_n=0 one cycle -> gnt=0 next edge; after release req=4'b0011 -> gnt_id=0.
//  6 Timeout (macro on): req=4'b0011 held constant -> gnt_id=0 for 4 cycles, then gnt=0 with timeout=1,
//    then gnt_id=1; after 1 times out, 0 still masked -> stays IDLE until req[0] drops and re-rises.
//    Macro off, same stimulus -> gnt_id=0 held indefinitely, timeout=0.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with locked grants and a one-cycle bubble between owners.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);

  if ((N_REQ < 2) || ((N_REQ & (N_REQ - 1)) != 0) || (MAX_HOLD < 1)) begin : g_bad_params
    $error("rr_grant_arbiter: N_REQ must be a power of two >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r;
  logic [IW-1:0]    ptr_r;
  logic [N_REQ-1:0] elig_s;
  logic [IW-1:0]    sel_s;
  logic             found_s;
  logic             owner_req_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]    hold_cnt_r;
  logic [N_REQ-1:0] mask_r;
  logic             expire_s;

  // Eligibility excludes requesters still parked after a forced release.
  always_comb begin
    elig_s   = req & ~mask_r;
    expire_s = (hold_cnt_r == HW'(MAX_HOLD - 1)) && owner_req_s;
  end
`else
  // Without the timeout feature every raised request is eligible.
  always_comb begin
    elig_s = req;
  end
`endif

  // Owner's request level; ptr arithmetic wraps naturally at IW bits.
  always_comb begin
    owner_req_s = req[gnt_id];
  end

  // Scan downward so the smallest offset from ptr_r wins.
  always_comb begin
    sel_s   = ptr_r;
    found_s = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig_s[ptr_r + IW'(i)]) begin
        sel_s   = ptr_r + IW'(i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= {IW{1'b0}};
      gnt       <= {N_REQ{1'b0}};
      gnt_id    <= {IW{1'b0}};
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_cnt_r <= {HW{1'b0}};
      mask_r     <= {N_REQ{1'b0}};
`endif
    end else begin
      timeout <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      mask_r <= mask_r & req;
`endif
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt       <= onehot(sel_s);
            gnt_id    <= sel_s;
            gnt_valid <= 1'b1;
            state_r   <= GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_r <= {HW{1'b0}};
`endif
          end else begin
            gnt       <= {N_REQ{1'b0}};
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            gnt       <= {N_REQ{1'b0}};
            gnt_valid <= 1'b0;
            ptr_r     <= gnt_id + IW'(1);
            state_r   <= IDLE;
`ifdef ARB_HOLD_TIMEOUT_EN
          end else if (expire_s) begin
            // Forced release; owner stays masked until it drops its request.
            gnt       <= {N_REQ{1'b0}};
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            ptr_r     <= gnt_id + IW'(1);
            mask_r    <= (mask_r & req) | onehot(gnt_id);
            state_r   <= IDLE;
          end else begin
            if (hold_cnt_r != {HW{1'b1}}) begin
              hold_cnt_r <= hold_cnt_r + HW'(1);
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
`else
          end else begin
            state_r <= GRANT;
`endif
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt       <= {N_REQ{1'b0}};
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
